pool_sched: RTL and testbench

POOL_SCHED -- requirements
Module: pool_sched

---
 rtl/pool_sched.sv | 197 +++++++++++++++++++
 tb/tb_pool_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_sched.sv
// Purpose : job scheduler for a 2x2 max-pool unit. It streams cols*rows*chans pixels
//           from feature memory into the pool unit and writes the pooled results to
//           result memory.
// Latency : a job goes IDLE -> CHECK -> STREAM (one read per cycle) -> DRAIN -> FIN.
//           pool_valid lags mem_rd_en by one cycle. Result writes are combinational,
//           in the same cycle as pool_valid_out.
// Backpr. : there is none. Reads issue every STREAM cycle without gaps, and the pool
//           unit must take one pixel per cycle. A DRAIN watchdog ends a stalled job.
//
// Ports   : clk / Rst_n            clock, async active-low reset
//           start, cfg_*           job request and geometry, latched in IDLE
//           mem_rd_*               feature-memory read port (1-cycle read latency)
//           pool_din/pool_valid    pixel stream into the pool unit
//           pool_result/_valid_out pooled stream back from the unit
//           wr_*                   result-memory write port
//           busy, done, err        status; done is a one-cycle pulse qualified by err
module pool_sched #(
   parameter int M         = 16,
   parameter int AW        = 20,
   parameter int DRAIN_MAX = 4096
) (
   input  logic          clk,
   input  logic          Rst_n,
   input  logic          start,
   input  logic [10:0]   cfg_cols,
   input  logic [10:0]   cfg_rows,
   input  logic [7:0]    cfg_chans,
   input  logic [AW-1:0] cfg_ibase,
   input  logic [AW-1:0] cfg_obase,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [M-1:0]  mem_rd_data,
   output logic [M-1:0]  pool_din,
   output logic          pool_valid,
   input  logic [M-1:0]  pool_result,
   input  logic          pool_valid_out,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [M-1:0]  wr_data,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int WDW = $clog2(DRAIN_MAX + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(DRAIN_MAX - 1);

   typedef enum logic [2:0] {IDLE, CHECK, STREAM, DRAIN, FIN} state_t;

   state_t        state;

   // job configuration, frozen for the whole job once start is accepted
   logic [10:0]   cols_q;
   logic [10:0]   rows_q;
   logic [7:0]    chans_q;
   logic [AW-1:0] ibase_q;
   logic [AW-1:0] obase_q;

   logic [23:0]   total_q;     // pixels to read
   logic [23:0]   n_q;         // pixel read index
   logic [27:0]   exp_q;       // expected pooled results
   logic [27:0]   k_q;         // results written so far
   logic [WDW-1:0] wd_q;       // consecutive idle DRAIN cycles
   logic          err_sticky;
   logic          done_r;
   logic          err_r;

   logic          in_xfer;
   logic          k_full;
   logic          accept;
   logic          stray;
   logic          cfg_bad;

   assign in_xfer = (state == STREAM) || (state == DRAIN);
   assign k_full  = (k_q == exp_q);
   assign accept  = pool_valid_out && in_xfer && !k_full;
   // A result the job cannot take. This covers surplus results, and results in
   // CHECK or FIN. In IDLE there is no job to blame, so the result is ignored.
   assign stray   = pool_valid_out &&
                    ((state == CHECK) || (state == FIN) || (in_xfer && k_full));
   assign cfg_bad = (cols_q == 11'd0) || (rows_q == 11'd0) || (chans_q == 8'd0) ||
                    cols_q[0] || rows_q[0];

   // Writes are combinational so each pooled result lands in the cycle it appears.
   assign wr_en    = accept;
   assign wr_addr  = accept ? (obase_q + AW'(k_q)) : '0;
   assign wr_data  = accept ? pool_result : '0;

   // Read data arrives one cycle after the request, which is when pool_valid is high.
   assign pool_din = pool_valid ? mem_rd_data : '0;

   assign busy = (state != IDLE);
   assign done = done_r;
   // A stray result in the FIN cycle still belongs to this job's status.
   assign err  = done_r & (err_r | pool_valid_out);

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= IDLE;
         cols_q      <= '0;
         rows_q      <= '0;
         chans_q     <= '0;
         ibase_q     <= '0;
         obase_q     <= '0;
         total_q     <= '0;
         n_q         <= '0;
         exp_q       <= '0;
         k_q         <= '0;
         wd_q        <= '0;
         err_sticky  <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         pool_valid  <= 1'b0;
      end else begin
         pool_valid <= mem_rd_en;

         case (state)
            IDLE: begin
               if (start) begin
                  cols_q     <= cfg_cols;
                  rows_q     <= cfg_rows;
                  chans_q    <= cfg_chans;
                  ibase_q    <= cfg_ibase;
                  obase_q    <= cfg_obase;
                  err_sticky <= 1'b0;
                  state      <= CHECK;
               end
            end

            CHECK: begin
               n_q     <= '0;
               k_q     <= '0;
               wd_q    <= '0;
               // The pixel count wraps at 24 bits. Odd sizes are rejected below,
               // so halving with a bit drop is exact for the result count.
               total_q <= 24'(cols_q) * 24'(rows_q) * 24'(chans_q);
               exp_q   <= 28'(cols_q[10:1]) * 28'(rows_q[10:1]) * 28'(chans_q);
               if (stray)
                  err_sticky <= 1'b1;
               if (cfg_bad) begin
                  state  <= FIN;
                  done_r <= 1'b1;
                  err_r  <= 1'b1;
               end else begin
                  state       <= STREAM;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= ibase_q;
               end
            end

            STREAM: begin
               if (accept)
                  k_q <= k_q + 28'd1;
               if (stray)
                  err_sticky <= 1'b1;
               if (n_q == total_q - 24'd1) begin
                  mem_rd_en   <= 1'b0;
                  mem_rd_addr <= '0;
                  wd_q        <= '0;
                  state       <= DRAIN;
               end else begin
                  n_q         <= n_q + 24'd1;
                  mem_rd_addr <= mem_rd_addr + AW'(1);
               end
            end

            DRAIN: begin
               if (accept)
                  k_q <= k_q + 28'd1;
               if (k_full) begin
                  state  <= FIN;
                  done_r <= 1'b1;
                  err_r  <= err_sticky | stray;
               end else if (!pool_valid_out && (wd_q == WD_LAST)) begin
                  // DRAIN_MAX consecutive cycles without a result: give up.
                  state  <= FIN;
                  done_r <= 1'b1;
                  err_r  <= 1'b1;
               end else begin
                  wd_q <= pool_valid_out ? '0 : wd_q + WDW'(1);
               end
            end

            FIN: begin
               done_r <= 1'b0;
               err_r  <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pool_sched.sv
// Purpose : directed bench for pool_sched. It checks reads, the pixel stream,
//           result writes and done/err timing against hand-computed values.
// Latency : the bench drives inputs 1 time unit after the rising edge and samples on
//           the falling edge.
// Backpr. : none. The bench injects pooled results on chosen cycles.
module tb_pool_sched;

   logic        clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] cfg_cols = '0;
   logic [10:0] cfg_rows = '0;
   logic [7:0]  cfg_chans = '0;
   logic [19:0] cfg_ibase = '0;
   logic [19:0] cfg_obase = '0;
   logic        mem_rd_en;
   logic [19:0] mem_rd_addr;
   logic [15:0] mem_rd_data = '0;
   logic [15:0] pool_din;
   logic        pool_valid;
   logic [15:0] pool_result = '0;
   logic        pool_valid_out = 1'b0;
   logic        wr_en;
   logic [19:0] wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        done;
   logic        err;

   pool_sched #(.M(16), .AW(20), .DRAIN_MAX(16)) dut (
      .clk(clk), .Rst_n(Rst_n), .start(start),
      .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_chans(cfg_chans),
      .cfg_ibase(cfg_ibase), .cfg_obase(cfg_obase),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .pool_din(pool_din), .pool_valid(pool_valid),
      .pool_result(pool_result), .pool_valid_out(pool_valid_out),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] memf(input logic [19:0] a);
      return a[15:0] ^ 16'h3C3C;
   endfunction

   // feature memory with one-cycle read latency
   always @(posedge clk) mem_rd_data <= mem_rd_en ? memf(mem_rd_addr) : 16'h0;

   int vectors = 0;
   int miscompares = 0;

   logic [19:0] rd_q[$];
   logic [15:0] pool_q[$];
   logic [19:0] wa_q[$];
   logic [15:0] wd_q[$];
   int rd_first_cyc, rd_last_cyc, pool_first_cyc;
   int done_cnt = 0;
   int done_cyc = 0;
   logic done_err = 1'b0;
   int start_cyc = 0;
   int job_done0 = 0;

   always @(negedge clk) begin
      if (mem_rd_en) begin
         if (rd_q.size() == 0) rd_first_cyc = cyc;
         rd_q.push_back(mem_rd_addr);
         rd_last_cyc = cyc;
      end
      if (pool_valid) begin
         if (pool_q.size() == 0) pool_first_cyc = cyc;
         pool_q.push_back(pool_din);
      end
      if (wr_en) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
      end
      if (done) begin
         done_cnt++;
         done_err = err;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_q.delete();
      pool_q.delete();
      wa_q.delete();
      wd_q.delete();
      rd_first_cyc = 0;
      rd_last_cyc = 0;
      pool_first_cyc = 0;
   endtask

   task automatic launch(input logic [10:0] c, input logic [10:0] r, input logic [7:0] ch,
                         input logic [19:0] ib, input logic [19:0] ob);
      clear_logs();
      cfg_cols = c;
      cfg_rows = r;
      cfg_chans = ch;
      cfg_ibase = ib;
      cfg_obase = ob;
      job_done0 = done_cnt;
      start_cyc = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_reads(input string tag, input int n);
      int t = 0;
      while ((rd_q.size() < n || mem_rd_en) && t < 500) begin
         tick();
         t++;
      end
      chk({tag, "_nrd"}, rd_q.size(), n);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int t = 0;
      while (done_cnt == job_done0 && t < budget) begin
         tick();
         t++;
      end
      chk({tag, "_done"}, done_cnt - job_done0, 1);
   endtask

   task automatic send(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         pool_valid_out = 1'b1;
         pool_result = base + 16'(i);
         tick();
      end
      pool_valid_out = 1'b0;
      pool_result = '0;
   endtask

   task automatic check_reads(input string tag, input logic [19:0] ib, input int n);
      int bad = 0;
      int pbad = 0;
      for (int i = 0; i < rd_q.size(); i++)
         if (rd_q[i] !== ib + 20'(i)) bad++;
      chk({tag, "_rd_addr"}, bad, 0);
      chk({tag, "_rd_span"}, rd_last_cyc - rd_first_cyc, n - 1);
      chk({tag, "_npool"}, pool_q.size(), n);
      for (int i = 0; i < pool_q.size(); i++)
         if (pool_q[i] !== memf(ib + 20'(i))) pbad++;
      chk({tag, "_pool_din"}, pbad, 0);
      chk({tag, "_pool_lag"}, pool_first_cyc - rd_first_cyc, 1);
   endtask

   task automatic check_writes(input string tag, input logic [19:0] ob, input int n,
                               input logic [15:0] base);
      int bad = 0;
      chk({tag, "_nwr"}, wa_q.size(), n);
      for (int i = 0; i < wa_q.size(); i++)
         if (wa_q[i] !== ob + 20'(i) || wd_q[i] !== base + 16'(i)) bad++;
      chk({tag, "_wr"}, bad, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not reach its end");
      $fatal(1, "bench timed out");
   end

   initial begin
      // reset state, checked before any clock edge
      #2;
      chk("rst_ctl", {busy, done, err, mem_rd_en, pool_valid, wr_en}, 0);
      chk("rst_rdaddr", mem_rd_addr, 0);
      chk("rst_wr", {wr_addr, wr_data, pool_din}, 0);
      repeat (2) @(posedge clk);
      #1 Rst_n = 1'b1;
      tick();

      // basic 4x2x1 job
      launch(11'd4, 11'd2, 8'd1, 20'h00100, 20'h00200);
      wait_reads("s1", 8);
      send(2, 16'hA000);
      wait_done("s1", 50);
      check_reads("s1", 20'h00100, 8);
      check_writes("s1", 20'h00200, 2, 16'hA000);
      chk("s1_err", done_err, 0);

      // odd cols: rejected in CHECK, done 2 cycles after start
      launch(11'd3, 11'd2, 8'd1, 20'h00100, 20'h00200);
      wait_done("s2", 20);
      chk("s2_nrd", rd_q.size(), 0);
      chk("s2_lat", done_cyc - start_cyc, 2);
      chk("s2_err", done_err, 1);

      // zero rows: rejected
      launch(11'd4, 11'd0, 8'd1, 20'h00100, 20'h00200);
      wait_done("s2b", 20);
      chk("s2b_lat", done_cyc - start_cyc, 2);
      chk("s2b_err", done_err, 1);

      // two channels back to back
      launch(11'd4, 11'd2, 8'd2, 20'h00300, 20'h00400);
      wait_reads("s3", 16);
      send(4, 16'hB000);
      wait_done("s3", 50);
      check_reads("s3", 20'h00300, 16);
      check_writes("s3", 20'h00400, 4, 16'hB000);
      chk("s3_err", done_err, 0);

      // one surplus result: not written, job flags err
      launch(11'd4, 11'd2, 8'd1, 20'h00000, 20'h00010);
      wait_reads("s3b", 8);
      send(3, 16'hC000);
      wait_done("s3b", 50);
      check_writes("s3b", 20'h00010, 2, 16'hC000);
      chk("s3b_err", done_err, 1);

      // results withheld: watchdog fires 16 cycles after DRAIN entry
      launch(11'd4, 11'd2, 8'd1, 20'h00000, 20'h00020);
      wait_reads("s4", 8);
      wait_done("s4", 100);
      chk("s4_wd_lat", done_cyc - rd_last_cyc, 17);
      chk("s4_err", done_err, 1);
      chk("s4_nwr", wa_q.size(), 0);

      // start and cfg changes mid-job have no effect
      launch(11'd4, 11'd2, 8'd1, 20'h00500, 20'h00600);
      repeat (3) tick();
      cfg_cols = 11'd8;
      cfg_chans = 8'd3;
      cfg_ibase = 20'h00700;
      cfg_obase = 20'h00900;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_reads("s5", 8);
      send(2, 16'hD000);
      wait_done("s5", 50);
      check_reads("s5", 20'h00500, 8);
      check_writes("s5", 20'h00600, 2, 16'hD000);
      chk("s5_err", done_err, 0);
      repeat (10) tick();
      chk("s5_one_done", done_cnt - job_done0, 1);
      chk("s5_idle", busy, 0);

      // reset mid-STREAM: outputs clear at once, no done, then a clean rerun
      launch(11'd4, 11'd2, 8'd1, 20'h00800, 20'h00A00);
      repeat (3) tick();
      chk("s6_pre_rd", mem_rd_en, 1);
      Rst_n = 1'b0;
      #1;
      chk("s6_rst_ctl", {busy, done, err, mem_rd_en, pool_valid, wr_en}, 0);
      chk("s6_rst_addr", mem_rd_addr, 0);
      chk("s6_rst_din", pool_din, 0);
      tick();
      Rst_n = 1'b1;
      repeat (10) tick();
      chk("s6_no_done", done_cnt - job_done0, 0);
      launch(11'd4, 11'd2, 8'd1, 20'h00800, 20'h00A00);
      wait_reads("s6r", 8);
      send(2, 16'hE000);
      wait_done("s6r", 50);
      check_reads("s6r", 20'h00800, 8);
      check_writes("s6r", 20'h00A00, 2, 16'hE000);
      chk("s6r_err", done_err, 0);

      // address wrap at 2^20 on both ports, no error
      launch(11'd4, 11'd2, 8'd1, 20'hFFFFE, 20'hFFFFF);
      wait_reads("s7", 8);
      send(2, 16'hF000);
      wait_done("s7", 50);
      check_reads("s7", 20'hFFFFE, 8);
      check_writes("s7", 20'hFFFFF, 2, 16'hF000);
      chk("s7_err", done_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
